// File: rtl/method_call_sequencer_if.sv
// Method-call handshake between the sequencer (master) and a generated callee (slave).
// The request is a one-cycle pulse; busy lags it by a cycle and the return is valid when busy drops.
interface method_call_sequencer_if #(
  parameter int unsigned RET_W = 1
);
  logic             method_req;
  logic             method_busy;
  logic [RET_W-1:0] method_return;

  modport master (
    output method_req,
    input  method_busy,
    input  method_return
  );

  modport slave (
    input  method_req,
    output method_busy,
    output method_return
  );
endinterface

// File: rtl/method_call_sequencer.sv
// Issues RUNS method calls to a req/busy/return callee, times each call and checks the return
// against EXPECT, ending in sticky done/pass/fail/timeout flags.
module method_call_sequencer #(
  parameter int unsigned RET_W       = 1,
  parameter int unsigned EXPECT      = 1,
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned RUNS        = 1,
  parameter int unsigned ACK_WAIT    = 4,
  parameter int unsigned TIMEOUT     = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  method_call_sequencer_if.master io_call,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_fail,
  output logic                    o_timeout,
  output logic [15:0]             o_run_count,
  output logic [31:0]             o_last_cycles,
  output logic [15:0]             o_mismatch_count
);

  localparam logic [RET_W-1:0] EXP_VAL    = RET_W'(EXPECT);
  localparam logic [31:0]      DELAY_LOAD = (START_DELAY == 0) ? 32'd0 : 32'(START_DELAY - 1);
  // Cycle counter is 1 in the REQ cycle, so ACK_WAIT idle cycles end at ACK_WAIT + 1.
  localparam logic [31:0]      ACK_LIMIT  = 32'(ACK_WAIT) + 32'd1;
  localparam logic [31:0]      BUSY_LIMIT = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StReq,
    StWaitAck,
    StWaitDone,
    StCheck,
    StFinish
  } state_e;

  state_e           r_state;
  logic             r_req;
  logic [31:0]      r_delay;
  logic [31:0]      r_cycles;
  logic [RET_W-1:0] r_ret;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [15:0]      r_run_count;
  logic [31:0]      r_last_cycles;
  logic [15:0]      r_mismatch_count;

  logic [31:0]      w_cyc_inc;
  logic [15:0]      w_run_inc;
  logic [15:0]      w_mis_next;
  logic             w_more_runs;

  always_comb begin
    w_cyc_inc   = (&r_cycles) ? r_cycles : r_cycles + 32'd1;
    w_run_inc   = (&r_run_count) ? r_run_count : r_run_count + 16'd1;
    w_mis_next  = r_mismatch_count;
    if (r_ret != EXP_VAL) begin
      w_mis_next = (&r_mismatch_count) ? r_mismatch_count : r_mismatch_count + 16'd1;
    end
    w_more_runs = (32'(r_run_count) + 32'd1) < RUNS;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state          <= StIdle;
      r_req            <= 1'b0;
      r_delay          <= 32'd0;
      r_cycles         <= 32'd0;
      r_ret            <= '0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail           <= 1'b0;
      r_timeout        <= 1'b0;
      r_run_count      <= 16'd0;
      r_last_cycles    <= 32'd0;
      r_mismatch_count <= 16'd0;
    end else begin
      // The request is registered, so it is raised on every transition into StReq only.
      r_req <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_run_count      <= 16'd0;
            r_mismatch_count <= 16'd0;
            r_last_cycles    <= 32'd0;
            if (START_DELAY == 0) begin
              r_state  <= StReq;
              r_req    <= 1'b1;
              r_cycles <= 32'd1;
            end else begin
              r_delay <= DELAY_LOAD;
              r_state <= StDelay;
            end
          end
        end
        StDelay: begin
          if (r_delay == 32'd0) begin
            r_state  <= StReq;
            r_req    <= 1'b1;
            r_cycles <= 32'd1;
          end else begin
            r_delay <= r_delay - 32'd1;
          end
        end
        StReq: begin
          r_cycles <= w_cyc_inc;
          r_state  <= StWaitAck;
        end
        StWaitAck: begin
          r_cycles <= w_cyc_inc;
          if (io_call.method_busy) begin
            r_state <= StWaitDone;
          end else if (r_cycles >= ACK_LIMIT) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
            r_state   <= StFinish;
          end
        end
        StWaitDone: begin
          r_cycles <= w_cyc_inc;
          // Completion is tested first so it wins over a limit reached in the same cycle.
          if (!io_call.method_busy) begin
            r_ret         <= io_call.method_return;
            r_last_cycles <= r_cycles;
            r_state       <= StCheck;
          end else if (r_cycles >= BUSY_LIMIT) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
            r_state   <= StFinish;
          end
        end
        StCheck: begin
          r_run_count      <= w_run_inc;
          r_mismatch_count <= w_mis_next;
          if (w_more_runs) begin
            r_state  <= StReq;
            r_req    <= 1'b1;
            r_cycles <= 32'd1;
          end else begin
            r_done  <= 1'b1;
            r_pass  <= (w_mis_next == 16'd0);
            r_fail  <= (w_mis_next != 16'd0);
            r_state <= StFinish;
          end
        end
        StFinish: begin
          r_state <= StFinish;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_call.method_req = r_req;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_fail             = r_fail;
  assign o_timeout          = r_timeout;
  assign o_run_count        = r_run_count;
  assign o_last_cycles      = r_last_cycles;
  assign o_mismatch_count   = r_mismatch_count;

endmodule

// File: tb/tb_method_call_sequencer.sv
// Directed bench: two sequencers (single-run and three-run) each driven by a scripted callee.
module tb_method_call_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        done_a, pass_a, fail_a, tmo_a;
  logic [15:0] run_a, mis_a;
  logic [31:0] last_a;
  logic        done_b, pass_b, fail_b, tmo_b;
  logic [15:0] run_b, mis_b;
  logic [31:0] last_b;

  method_call_sequencer_if #(.RET_W(1)) if_a ();
  method_call_sequencer_if #(.RET_W(1)) if_b ();

  method_call_sequencer #(
    .RET_W(1), .EXPECT(1), .START_DELAY(100), .RUNS(1), .ACK_WAIT(4), .TIMEOUT(50)
  ) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_start(start_a), .io_call(if_a),
    .o_done(done_a), .o_pass(pass_a), .o_fail(fail_a), .o_timeout(tmo_a),
    .o_run_count(run_a), .o_last_cycles(last_a), .o_mismatch_count(mis_a)
  );

  method_call_sequencer #(
    .RET_W(1), .EXPECT(1), .START_DELAY(3), .RUNS(3), .ACK_WAIT(4), .TIMEOUT(50)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_start(start_b), .io_call(if_b),
    .o_done(done_b), .o_pass(pass_b), .o_fail(fail_b), .o_timeout(tmo_b),
    .o_run_count(run_b), .o_last_cycles(last_b), .o_mismatch_count(mis_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Callee A: mode 0 = normal, 1 = never busy, 2 = busy until mode changes.
  int   mode_a = 0;
  int   hold_a = 10;
  int   mode_b = 0;
  int   hold_b = 10;
  logic rets_b [3];
  int   idx_b = 0;

  initial begin
    if_a.method_busy = 1'b0;
    if_a.method_return = 1'b0;
    forever begin
      @(negedge clk);
      if (if_a.method_req && mode_a != 1) begin
        @(negedge clk);
        if_a.method_busy = 1'b1;
        if (mode_a == 2) begin
          while (mode_a == 2) @(negedge clk);
        end else begin
          repeat (hold_a) @(negedge clk);
        end
        if_a.method_return = 1'b1;
        if_a.method_busy = 1'b0;
      end
    end
  end

  initial begin
    if_b.method_busy = 1'b0;
    if_b.method_return = 1'b0;
    forever begin
      @(negedge clk);
      if (if_b.method_req && mode_b != 1) begin
        @(negedge clk);
        if_b.method_busy = 1'b1;
        repeat (hold_b) @(negedge clk);
        if_b.method_return = (idx_b < 3) ? rets_b[idx_b] : 1'b1;
        idx_b++;
        if_b.method_busy = 1'b0;
      end
    end
  end

  // Request monitors: high cycles and rising edges must match for one-cycle pulses.
  int   reqhi_a = 0, rise_a = 0, reqhi_b = 0, rise_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (if_a.method_req) reqhi_a++;
      if (if_a.method_req && !prev_a) rise_a++;
      prev_a = if_a.method_req;
      if (if_b.method_req) reqhi_b++;
      if (if_b.method_req && !prev_b) rise_b++;
      prev_b = if_b.method_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_a();
    int k;
    k = 0;
    while (if_a.method_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    rst_a = 1'b0;
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    #1;
    reqhi_a = 0;
    rise_a = 0;
  endtask

  task automatic reset_b();
    int k;
    k = 0;
    while (if_b.method_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    rst_b = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    idx_b = 0;
    @(negedge clk);
    #1;
    reqhi_b = 0;
    rise_b = 0;
  endtask

  // Pulse start_a and return the cycle (start cycle = 0) in which method_req is seen.
  task automatic start_find_req_a(output int cyc);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 1;
    while (!if_a.method_req && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done_a(output int k);
    k = 0;
    while (!done_a && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_done_b(output int k);
    k = 0;
    while (!done_b && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a, if_a.method_req} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags_a: got %b, expected 00000",
               {done_a, pass_a, fail_a, tmo_a, if_a.method_req});
    end
    n_checks++;
    if ({run_a, mis_a, last_a} !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_counts_a: got %0d/%0d/%0d, expected 0/0/0", run_a, mis_a, last_a);
    end
    n_checks++;
    if ({done_b, pass_b, fail_b, tmo_b, run_b, mis_b, last_b} !== 68'd0) begin
      n_errors++;
      $display("FAIL reset_b: got done=%b run=%0d last=%0d, expected all zero",
               done_b, run_b, last_b);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (reqhi_a + reqhi_b !== 0) begin
      n_errors++;
      $display("FAIL reset_start_ignored: got %0d req cycles, expected 0", reqhi_a + reqhi_b);
    end
  endtask

  task automatic test_single_call();
    int cyc, k;
    mode_a = 0;
    hold_a = 10;
    start_find_req_a(cyc);
    n_checks++;
    if (cyc !== 101) begin
      n_errors++;
      $display("FAIL single_req_cycle: got %0d, expected 101", cyc);
    end
    wait_done_a(k);
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1100) begin
      n_errors++;
      $display("FAIL single_flags: got %b, expected 1100", {done_a, pass_a, fail_a, tmo_a});
    end
    n_checks++;
    if (run_a !== 16'd1 || mis_a !== 16'd0) begin
      n_errors++;
      $display("FAIL single_counts: got run=%0d mis=%0d, expected run=1 mis=0", run_a, mis_a);
    end
    n_checks++;
    if (last_a !== 32'd12) begin
      n_errors++;
      $display("FAIL single_last_cycles: got %0d, expected 12", last_a);
    end
  endtask

  task automatic test_multi_run();
    int k;
    rets_b[0] = 1'b1;
    rets_b[1] = 1'b0;
    rets_b[2] = 1'b1;
    idx_b = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_done_b(k);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({done_b, pass_b, fail_b, tmo_b} !== 4'b1010) begin
      n_errors++;
      $display("FAIL multi_flags: got %b, expected 1010", {done_b, pass_b, fail_b, tmo_b});
    end
    n_checks++;
    if (run_b !== 16'd3 || mis_b !== 16'd1) begin
      n_errors++;
      $display("FAIL multi_counts: got run=%0d mis=%0d, expected run=3 mis=1", run_b, mis_b);
    end
    n_checks++;
    if (reqhi_b !== 3 || rise_b !== 3) begin
      n_errors++;
      $display("FAIL multi_req_pulses: got %0d cycles/%0d pulses, expected 3/3", reqhi_b, rise_b);
    end
    n_checks++;
    if (last_b !== 32'd12) begin
      n_errors++;
      $display("FAIL multi_last_cycles: got %0d, expected 12", last_b);
    end
  endtask

  task automatic test_ack_timeout();
    int cyc, k;
    reset_a();
    mode_a = 1;
    start_find_req_a(cyc);
    k = 0;
    while (!done_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k !== 5) begin
      n_errors++;
      $display("FAIL ack_done_latency: got %0d, expected 5", k);
    end
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1011 || run_a !== 16'd0) begin
      n_errors++;
      $display("FAIL ack_flags: got %b run=%0d, expected 1011 run=0",
               {done_a, pass_a, fail_a, tmo_a}, run_a);
    end
    mode_a = 0;
  endtask

  task automatic test_busy_timeout();
    int cyc, k;
    reset_a();
    mode_a = 2;
    start_find_req_a(cyc);
    k = 0;
    while (!tmo_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k !== 50) begin
      n_errors++;
      $display("FAIL busy_timeout_latency: got %0d, expected 50", k);
    end
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1011 || run_a !== 16'd0) begin
      n_errors++;
      $display("FAIL busy_timeout_flags: got %b run=%0d, expected 1011 run=0",
               {done_a, pass_a, fail_a, tmo_a}, run_a);
    end
    n_checks++;
    if (reqhi_a !== 1) begin
      n_errors++;
      $display("FAIL busy_timeout_no_reissue: got %0d req cycles, expected 1", reqhi_a);
    end
    mode_a = 0;
    repeat (2) @(negedge clk);
  endtask

  // Busy low on the cycle the counter hits TIMEOUT completes; one cycle longer times out.
  task automatic test_timeout_boundary();
    int cyc, k;
    reset_a();
    hold_a = 48;
    start_find_req_a(cyc);
    wait_done_a(k);
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1100 || last_a !== 32'd50) begin
      n_errors++;
      $display("FAIL boundary_complete: got %b last=%0d, expected 1100 last=50",
               {done_a, pass_a, fail_a, tmo_a}, last_a);
    end
    reset_a();
    hold_a = 49;
    start_find_req_a(cyc);
    wait_done_a(k);
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1011 || run_a !== 16'd0) begin
      n_errors++;
      $display("FAIL boundary_timeout: got %b run=%0d, expected 1011 run=0",
               {done_a, pass_a, fail_a, tmo_a}, run_a);
    end
    hold_a = 10;
  endtask

  task automatic test_reset_mid_call();
    int k;
    reset_b();
    rets_b[0] = 1'b1;
    rets_b[1] = 1'b1;
    rets_b[2] = 1'b1;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    k = 0;
    while (run_b != 16'd1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (!if_b.method_busy || last_b !== 32'd12) begin
      n_errors++;
      $display("FAIL midcall_setup: got busy=%b last=%0d, expected busy=1 last=12",
               if_b.method_busy, last_b);
    end
    #2;
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({done_b, fail_b, tmo_b, if_b.method_req, run_b, mis_b, last_b} !== 68'd0) begin
      n_errors++;
      $display("FAIL midcall_async_reset: got run=%0d last=%0d req=%b, expected 0/0/0",
               run_b, last_b, if_b.method_req);
    end
    k = 0;
    while (if_b.method_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_b = 1'b1;
    idx_b = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_done_b(k);
    n_checks++;
    if ({done_b, pass_b, fail_b, tmo_b} !== 4'b1100 || run_b !== 16'd3 || mis_b !== 16'd0) begin
      n_errors++;
      $display("FAIL midcall_rerun: got %b run=%0d mis=%0d, expected 1100 run=3 mis=0",
               {done_b, pass_b, fail_b, tmo_b}, run_b, mis_b);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, k;
    reset_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 1;
    while (!if_a.method_req && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == 10);
    end
    start_a = 1'b0;
    n_checks++;
    if (cyc !== 101) begin
      n_errors++;
      $display("FAIL delay_start_ignored: got req at %0d, expected 101", cyc);
    end
    wait_done_a(k);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (150) @(negedge clk);
    #1;
    n_checks++;
    if (reqhi_a !== 1) begin
      n_errors++;
      $display("FAIL finish_start_ignored: got %0d req cycles, expected 1", reqhi_a);
    end
    n_checks++;
    if ({done_a, pass_a, fail_a, tmo_a} !== 4'b1100 || run_a !== 16'd1 || last_a !== 32'd12) begin
      n_errors++;
      $display("FAIL finish_flags_held: got %b run=%0d last=%0d, expected 1100 run=1 last=12",
               {done_a, pass_a, fail_a, tmo_a}, run_a, last_a);
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_multi_run();
    test_ack_timeout();
    test_busy_timeout();
    test_timeout_boundary();
    test_reset_mid_call();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/method_call_sequencer.md
Name: method_call_sequencer

Overview:
Drives the req/busy/return method-call interface of a Synthesijer-generated module, and runs in-hardware self-checks of that interface. It issues a configurable number of method invocations, times each one, and compares each return value against an expected constant. It produces sticky done/pass/fail/timeout flags plus a per-call cycle count. It sits directly upstream of the generated module: its method_req feeds the module's <method>_req, and it consumes the module's <method>_busy and <method>_return.

Parameters:
RET_W, 1, width of the method return value
EXPECT, 1, expected return value, compared at RET_W bits
START_DELAY, 100, cycles to wait after start before the first request (min 0)
RUNS, 1, number of invocations to issue (min 1)
ACK_WAIT, 4, max cycles from req pulse to busy rising before the call counts as a timeout
TIMEOUT, 100000, max cycles busy may stay high per call before timeout

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; accepted only in IDLE
method_req  out  1  one-cycle request pulse to the callee
method_busy  in  1  callee busy
method_return  in  RET_W  callee return value, valid in the cycle busy is observed low after the acknowledge
done  out  1  sticky; high once all runs have finished or a timeout has occurred
pass  out  1  sticky; done and no mismatch and no timeout
fail  out  1  sticky; done and (mismatch or timeout)
timeout  out  1  sticky; an ACK_WAIT or TIMEOUT limit expired
run_count  out  16  number of completed invocations
last_cycles  out  32  cycles from req pulse to busy-low sample for the last completed call
mismatch_count  out  16  number of returns not equal to EXPECT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0. Internal counters 0.
- While reset=0, start and method_busy are ignored.
- States are IDLE, DELAY, REQ, WAIT_ACK, WAIT_DONE, CHECK, FINISH.
- IDLE
  - start=1: clear run_count, mismatch_count and last_cycles, load the delay counter, go to DELAY.
  - If START_DELAY=0, go straight to REQ.
- DELAY: count START_DELAY cycles, then go to REQ.
- REQ: method_req=1 for exactly this cycle; the cycle counter is cleared to 1. Next state is WAIT_ACK.
- WAIT_ACK
  - method_busy=1: go to WAIT_DONE.
  - ACK_WAIT cycles pass without busy: set timeout and go to FINISH.
  - busy is never sampled in the REQ cycle itself (the callee's busy lags req by one cycle).
- WAIT_DONE
  - Cycle counter increments every cycle.
  - method_busy=0: capture method_return into a register, latch last_cycles from the cycle counter, go to CHECK.
  - Counter reaches TIMEOUT with busy still 1: set timeout and go to FINISH.
- CHECK
  - Increment run_count; increment mismatch_count if the captured return is not equal to EXPECT.
  - If run_count+1 < RUNS, go to REQ (back-to-back, no delay); otherwise go to FINISH.
- FINISH
  - done=1; pass = (mismatch_count==0 && !timeout); fail = !pass.
  - Hold these values until reset.
  - start is ignored in FINISH; only reset rearms the block.
- Counter limits:
  - run_count and mismatch_count saturate at 16'hFFFF.
  - The cycle counter saturates at 32'hFFFFFFFF; TIMEOUT fires first in practice.
- method_req is never high outside REQ. There is at most one outstanding call.
- If busy falls in the same cycle the TIMEOUT limit is reached, the completion wins: no timeout is flagged.
- If busy is already 1 when entering WAIT_ACK (a stale busy), it is treated as the acknowledge.
- Reset asserted mid-call returns the block to IDLE immediately and clears all flags. The callee is not notified.

Test Plan:
1. Callee model answers busy=1 one cycle after req, holds it 10 cycles, return=1; RUNS=1, START_DELAY=100; start at cycle 0 -> method_req pulses at cycle 101; done=1, pass=1, run_count=1, last_cycles=12, mismatch_count=0.
2. RUNS=3, callee returns 1, 0, 1 -> done=1, fail=1, mismatch_count=1, run_count=3; exactly 3 req pulses, each one cycle wide.
3. Callee never raises busy, ACK_WAIT=4 -> timeout=1, fail=1, run_count=0, done 5 cycles after the req pulse.
4. Callee holds busy forever, TIMEOUT=50 -> timeout=1, fail=1 exactly 50 cycles after the req pulse; method_req is not reissued.
5. Drive reset=0 during WAIT_DONE -> outputs go to 0 asynchronously, before the next clock edge. Re-pulse start after release -> sequence runs normally and passes.
6. Pulse start again in FINISH, and pulse start during DELAY -> both ignored; req count and flags are unchanged.
